// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-port memory responder: MMIO word offsets,
// STATUS bit positions and the address-region type.
package MIPS_DEF;

    // MMIO register word offsets (mem_addr[3:2]); byte offsets 0x0/0x4/0x8/0xC
    localparam logic [1:0] MMIO_CNT    = 2'd0;
    localparam logic [1:0] MMIO_CMP    = 2'd1;
    localparam logic [1:0] MMIO_STATUS = 2'd2;
    localparam logic [1:0] MMIO_GPIO   = 2'd3;

    localparam int STAT_TIMER = 0;
    localparam int STAT_BAD   = 1;
    localparam int STAT_ALIGN = 2;
    localparam int STATUS_W   = 3;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_BAD
    } addr_region_t;

endpackage

// File: rtl/mmio_timer.sv
// Cycle counter, timer compare and sticky W1C status; irq mirrors the timer-match bit.
// Latency: reads combinational, writes and status sets take effect at the next edge.
// Backpressure: none, every write strobe is accepted in its cycle.
module mmio_timer
    import MIPS_DEF::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  off,
    input  logic [31:0] wr_data,
    input  logic        bad_set,
    input  logic        align_set,
    output logic [31:0] rd_data,
    output logic        irq
);

    logic [31:0]         cnt_q;
    logic [31:0]         cmp_q;
    logic [STATUS_W-1:0] status_q;
    logic [STATUS_W-1:0] set_mask;
    logic [STATUS_W-1:0] w1c_mask;

    // Match uses the counter value before this edge's update
    always_comb begin
        set_mask             = '0;
        set_mask[STAT_TIMER] = (cnt_q == cmp_q);
        set_mask[STAT_BAD]   = bad_set;
        set_mask[STAT_ALIGN] = align_set;
        w1c_mask             = '0;
        if (wr_en && off == MMIO_STATUS)
            w1c_mask = wr_data[STATUS_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cmp_q    <= '1;
            status_q <= '0;
        end else begin
            if (wr_en && off == MMIO_CNT)
                cnt_q <= wr_data;
            else
                cnt_q <= cnt_q + 32'd1;
            if (wr_en && off == MMIO_CMP)
                cmp_q <= wr_data;
            // Set is OR-ed after the clear so a same-cycle set wins
            status_q <= (status_q & ~w1c_mask) | set_mask;
        end
    end

    always_comb begin
        rd_data = '0;
        case (off)
            MMIO_CNT:    rd_data = cnt_q;
            MMIO_CMP:    rd_data = cmp_q;
            MMIO_STATUS: rd_data = {{(32-STATUS_W){1'b0}}, status_q};
            default:     rd_data = '0;
        endcase
    end

    assign irq = status_q[STAT_TIMER];

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: local RAM plus a 16-byte MMIO window (CNT, CMP, STATUS, GPIO).
// Latency: read 0 cycles (combinational), write commits on the next edge.
// Backpressure: none; MEM_ALIGN_CHECK_EN adds suppression of misaligned accesses.
module data_mem_responder
    import MIPS_DEF::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_rd,
    input  logic        mem_wr,
    output logic [31:0] mem_rd_data,
    output logic [31:0] gpio_out,
    output logic        irq
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]  ram [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    addr_region_t region;
    logic         misalign;
    logic         wr_ok;
    logic         ram_we;
    logic         mmio_we;
    logic         bad_set;
    logic [1:0]   mmio_off;
    logic [31:0]  gpio_q;
    logic [31:0]  timer_rd;

    assign word_idx = mem_addr[AW+1:2];
    assign mmio_off = mem_addr[3:2];

    always_comb begin
        if ({1'b0, mem_addr} < RAM_BYTES)
            region = REGION_RAM;
        else if (mem_addr[31:4] == MMIO_BASE[31:4])
            region = REGION_MMIO;
        else
            region = REGION_BAD;
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (mem_rd | mem_wr) && (mem_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign wr_ok   = mem_wr && !misalign;
    assign ram_we  = wr_ok && rst_n && (region == REGION_RAM);
    assign mmio_we = wr_ok && (region == REGION_MMIO);
    assign bad_set = (mem_rd | mem_wr) && !misalign && (region == REGION_BAD);

    // RAM contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[word_idx] <= mem_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gpio_q <= '0;
        else if (mmio_we && mmio_off == MMIO_GPIO)
            gpio_q <= mem_wr_data;
    end

    mmio_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (mmio_we),
        .off       (mmio_off),
        .wr_data   (mem_wr_data),
        .bad_set   (bad_set),
        .align_set (misalign),
        .rd_data   (timer_rd),
        .irq       (irq)
    );

    always_comb begin
        mem_rd_data = '0;
        if (mem_rd && !misalign) begin
            case (region)
                REGION_RAM:  mem_rd_data = ram[word_idx];
                REGION_MMIO: mem_rd_data = (mmio_off == MMIO_GPIO) ? gpio_q : timer_rd;
                default:     mem_rd_data = '0;
            endcase
        end
    end

    assign gpio_out = gpio_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core datapath's data port (mem_addr / mem_wr_data / mem_rd_data / mem_rd / mem_wr).
- Serves word accesses from a local RAM and a small memory-mapped I/O window: free-running cycle counter, timer compare with interrupt, sticky status, and a general-purpose output register.
- Reads are combinational so the datapath captures data in the same cycle its MEM stage presents the address; writes commit on the clock edge.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two, at least 2.
- MMIO_BASE, 32'hFFFF_0000: base of the 16-byte I/O window; bits [3:0] must be zero.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- mem_addr  in  32  byte address from the datapath.
- mem_wr_data  in  32  write data.
- mem_rd  in  1  read strobe, one cycle per access.
- mem_wr  in  1  write strobe, one cycle per access.
- mem_rd_data  out  32  read data; combinational; 0 when mem_rd is low.
- gpio_out  out  32  general-purpose output register.
- irq  out  1  timer interrupt; equals status[0].

## Operation
Address decode, word index = mem_addr[AW+1:2] with AW = log2(DEPTH_WORDS):
- RAM region: mem_addr < DEPTH_WORDS*4.
- MMIO region: mem_addr[31:4] == MMIO_BASE[31:4].
- Any other address is a bad access: the read returns 0, the write is dropped, and status[1] sets.

RAM:
- Asynchronous read, synchronous write.
- Contents are not reset.

MMIO map, by offset:
- 0x0 CNT: 32-bit cycle counter, +1 every cycle, wraps 0xFFFF_FFFF to 0. A write loads mem_wr_data, and the write wins over the increment that cycle.
- 0x4 CMP: timer compare, read/write.
- 0x8 STATUS: bit0 timer match (sticky), bit1 bad address (sticky), bit2 misalign (sticky, macro only). Other bits read 0. Writing 1 to a bit clears it (W1C).
- 0xC GPIO: read/write; drives gpio_out.

Timer match:
- When CNT == CMP, status[0] sets at the next edge.
- The comparison uses the pre-update CNT value.

Simultaneous events:
- A set condition and a W1C on the same bit in the same cycle: the set wins.
- mem_rd and mem_wr both high: the write is performed, and mem_rd_data shows the pre-write contents.
- mem_rd_data is driven only from the region selected by mem_addr.

Reset values:
- CNT = 0, CMP = 32'hFFFF_FFFF, STATUS = 0, GPIO = 0.
- Therefore gpio_out = 0 and irq = 0.
- Reset asserted mid-access aborts that access; no RAM write occurs while rst_n is low.

## Timing
- Read latency 0: mem_rd_data is valid in the same cycle as mem_addr/mem_rd.
- Write latency 1: the data is visible to a read in the cycle after mem_wr.
- irq asserts 1 cycle after the cycle in which CNT == CMP.
- irq deasserts 1 cycle after the W1C write to STATUS bit0.
- The CNT value read in a cycle is the value before that edge's increment.
- No handshake or backpressure: every strobe completes in its cycle.

## Configuration
MEM_ALIGN_CHECK_EN:
- Defined: any mem_rd or mem_wr with mem_addr[1:0] != 0 is suppressed. The write is dropped, the read returns 0, and status[2] sets (sticky, W1C).
- Undefined: mem_addr[1:0] is ignored, status[2] reads 0, and no check logic is generated.

## Structure
Shared package MIPS_DEF gains:
- MMIO offset constants: MMIO_CNT, MMIO_CMP, MMIO_STATUS, MMIO_GPIO.
- STATUS bit index constants.
- An addr_region_t enum: REGION_RAM, REGION_MMIO, REGION_BAD.

One sub-module, mmio_timer:
- Contains CNT, CMP, STATUS and the match logic.
- Receives a decoded write strobe, offset and data, and returns read data and irq.

The top level holds the RAM array, address decode, GPIO register, alignment check and read mux.

## Test plan
- Reset, then read MMIO 0x0/0x4/0x8/0xC: response 0, 0xFFFF_FFFF, 0, 0; gpio_out = 0 and irq = 0.
- Write 0x1234_5678 to RAM 0x10, then read 0x10 on the next cycle: 0x1234_5678. Read 0x14 never written: no X checked. Read and write 0x10 with 0xAAAA_AAAA in the same cycle: read returns 0x1234_5678, and the next read returns 0xAAAA_AAAA.
- Write CMP = 20 and CNT = 10: irq rises exactly 11 cycles after the CNT write. Write 1 to STATUS bit0 in the match cycle: irq stays 1. Clear it later: irq falls 1 cycle after the W1C write.
- Write CNT = 0xFFFF_FFFE, then read twice on consecutive cycles: 0xFFFF_FFFF and then 0 (wrap).
- Read address 0x0800_0000: returns 0 and STATUS = 0x2. Write GPIO = 0xCAFE_F00D: gpio_out is 0xCAFE_F00D 1 cycle later.
- With MEM_ALIGN_CHECK_EN, write to 0x12: RAM word 0x10 is unchanged, STATUS bit2 = 1. Without the macro, the same write updates word 0x10.
- Assert rst_n low mid-run: all MMIO registers return asynchronously to their reset values, without waiting for a clock edge.
